// File: rtl/mips_defs.sv
// Shared MIPS multicycle definitions: opcodes, controller state encoding, ALUop codes
// and the bundle of datapath control strobes. ALU control imports this package as well.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b011;

  localparam logic [1:0] ASB_REG   = 2'b00;
  localparam logic [1:0] ASB_FOUR  = 2'b01;
  localparam logic [1:0] ASB_IMM   = 2'b10;
  localparam logic [1:0] ASB_BRIMM = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) || (op == OP_ADDI) ||
           (op == OP_SLTI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/control_out_decode.sv
// Moore decode of controller state into datapath strobes; only the strobes that
// complete a memory access look at mem_ready. Reset blanks every output.
module control_out_decode
  import mips_defs::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_opcode,
  input  logic        i_mem_ready,
  input  logic        i_rst,
  output ctrl_t       o_ctrl
);

  ctrl_t w_ctrl;

  always_comb begin
    w_ctrl = '0;
    if (!i_rst) begin
      case (i_state)
        S_FETCH: begin
          w_ctrl.mem_read  = 1'b1;
          w_ctrl.alu_src_b = ASB_FOUR;
          w_ctrl.alu_op    = ALU_ADD;
          w_ctrl.pc_source = PCS_ALU;
          w_ctrl.ir_write  = i_mem_ready;
          w_ctrl.pc_write  = i_mem_ready;
        end
        S_DECODE: begin
          w_ctrl.alu_src_b  = ASB_BRIMM;
          w_ctrl.alu_op     = ALU_ADD;
          w_ctrl.illegal_op = ~is_legal_op(i_opcode);
        end
        S_MEM_ADDR: begin
          w_ctrl.alu_src_a = 1'b1;
          w_ctrl.alu_src_b = ASB_IMM;
          w_ctrl.alu_op    = ALU_ADD;
        end
        S_MEM_READ: begin
          w_ctrl.mem_read = 1'b1;
          w_ctrl.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.mem_to_reg = 1'b1;
          w_ctrl.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          w_ctrl.mem_write  = 1'b1;
          w_ctrl.i_or_d     = 1'b1;
          w_ctrl.instr_done = i_mem_ready;
        end
        S_EXEC_R: begin
          w_ctrl.alu_src_a = 1'b1;
          w_ctrl.alu_src_b = ASB_REG;
          w_ctrl.alu_op    = ALU_RTYPE;
        end
        S_R_WB: begin
          w_ctrl.reg_dst    = 1'b1;
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.instr_done = 1'b1;
        end
        S_EXEC_I: begin
          w_ctrl.alu_src_a = 1'b1;
          w_ctrl.alu_src_b = ASB_IMM;
          w_ctrl.alu_op    = (i_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_I_WB: begin
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          w_ctrl.alu_src_a     = 1'b1;
          w_ctrl.alu_src_b     = ASB_REG;
          w_ctrl.alu_op        = ALU_SUB;
          w_ctrl.pc_write_cond = 1'b1;
          w_ctrl.pc_source     = PCS_ALUOUT;
          w_ctrl.instr_done    = 1'b1;
        end
        S_JUMP: begin
          w_ctrl.pc_write   = 1'b1;
          w_ctrl.pc_source  = PCS_JUMP;
          w_ctrl.instr_done = 1'b1;
        end
        default: w_ctrl = '0;
      endcase
    end
  end

  assign o_ctrl = w_ctrl;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register and next-state logic; the
// strobe decode lives in control_out_decode.
//   state     | meaning
//   FETCH     | read instruction, PC+4; waits on mem_ready
//   DECODE    | register read, branch target; dispatch on opcode
//   MEM_ADDR  | base + offset for lw/sw
//   MEM_READ  | data read; waits on mem_ready
//   MEM_WB    | load result to rt
//   MEM_WRITE | data write; waits on mem_ready
//   EXEC_R    | R-type ALU operation
//   R_WB      | ALU result to rd
//   EXEC_I    | addi/slti with immediate
//   I_WB      | ALU result to rt
//   BRANCH    | beq compare and conditional PC write
//   JUMP      | PC <= jump target
module multicycle_control
  import mips_defs::*;
#(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUop,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t r_state;
  state_t w_next_state;
  ctrl_t  w_ctrl;
  logic   w_mem_ready;

  assign w_mem_ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:     w_next_state = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     w_next_state = S_MEM_ADDR;
          OP_RTYPE:         w_next_state = S_EXEC_R;
          OP_ADDI, OP_SLTI: w_next_state = S_EXEC_I;
          OP_BEQ:           w_next_state = S_BRANCH;
          OP_J:             w_next_state = S_JUMP;
          default:          w_next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next_state = w_mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: w_next_state = w_mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    w_next_state = S_R_WB;
      S_EXEC_I:    w_next_state = S_I_WB;
      default:     w_next_state = S_FETCH;
    endcase
  end

  control_out_decode u_decode (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_mem_ready (w_mem_ready),
    .i_rst       (rst),
    .o_ctrl      (w_ctrl)
  );

  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign IorD        = w_ctrl.i_or_d;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign RegDst      = w_ctrl.reg_dst;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign PCSource    = w_ctrl.pc_source;
  assign ALUop       = w_ctrl.alu_op;
  assign instr_done  = w_ctrl.instr_done;
  assign illegal_op  = w_ctrl.illegal_op;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus walks each instruction's cycle path and queues the
// expected per-cycle control word; a negedge monitor pops and compares.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    logic       done, ill;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUop;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t sb_q[$];
  vec_t w_act;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_EN(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUop(ALUop), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  assign w_act = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop,
                  instr_done, illegal_op};

  // Expected control word for one cycle, straight from the per-state output table.
  function automatic vec_t model(input int s, input logic [5:0] op, input logic mr);
    vec_t v;
    logic legal;
    legal = (op == 6'b000000) || (op == 6'b000010) || (op == 6'b000100) ||
            (op == 6'b001000) || (op == 6'b001010) || (op == 6'b100011) ||
            (op == 6'b101011);
    v = '0;
    v.st = 4'(s);
    case (s)
      0:  begin v.mrd = 1; v.asb = 2'b01; v.aop = 3'b011; v.irw = mr; v.pcw = mr; end
      1:  begin v.asb = 2'b11; v.aop = 3'b011; v.ill = !legal; end
      2:  begin v.asa = 1; v.asb = 2'b10; v.aop = 3'b011; end
      3:  begin v.mrd = 1; v.iord = 1; end
      4:  begin v.rw = 1; v.m2r = 1; v.done = 1; end
      5:  begin v.mwr = 1; v.iord = 1; v.done = mr; end
      6:  begin v.asa = 1; v.aop = 3'b000; end
      7:  begin v.rdst = 1; v.rw = 1; v.done = 1; end
      8:  begin v.asa = 1; v.asb = 2'b10; v.aop = (op == 6'b001010) ? 3'b010 : 3'b011; end
      9:  begin v.rw = 1; v.done = 1; end
      10: begin v.asa = 1; v.aop = 3'b001; v.pcwc = 1; v.pcs = 2'b01; v.done = 1; end
      11: begin v.pcw = 1; v.pcs = 2'b10; v.done = 1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic step(input int s, input logic mr);
    mem_ready = mr;
    sb_q.push_back(model(s, opcode, mr));
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string name, input vec_t exp);
    n_vec++;
    if (w_act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, w_act, exp);
    end
  endtask

  // One instruction from FETCH to retire. Stall counts are extra cycles with
  // mem_ready low; abort pulls reset in the first MEM_WRITE cycle.
  task automatic run_instr(input logic [5:0] op, input int f_stall, input int m_stall,
                           input bit abort);
    opcode = op;
    for (int i = 0; i < f_stall; i++) step(0, 1'b0);
    step(0, 1'b1);
    step(1, 1'($urandom_range(0, 1)));
    case (op)
      6'b100011: begin
        step(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < m_stall; i++) step(3, 1'b0);
        step(3, 1'b1);
        step(4, 1'($urandom_range(0, 1)));
      end
      6'b101011: begin
        step(2, 1'($urandom_range(0, 1)));
        if (abort) begin
          mem_ready = 1'b0;
          #2 rst = 1'b1;
          #1 check_now("abort_memwrite", '0);
          @(posedge clk);
          #1 check_now("held_in_reset", '0);
          rst = 1'b0;
        end else begin
          for (int i = 0; i < m_stall; i++) step(5, 1'b0);
          step(5, 1'b1);
        end
      end
      6'b000000: begin step(6, 1'($urandom_range(0, 1))); step(7, 1'($urandom_range(0, 1))); end
      6'b001000, 6'b001010: begin
        step(8, 1'($urandom_range(0, 1)));
        step(9, 1'($urandom_range(0, 1)));
      end
      6'b000100: step(10, 1'($urandom_range(0, 1)));
      6'b000010: step(11, 1'($urandom_range(0, 1)));
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      vec_t e;
      e = sb_q.pop_front();
      n_vec++;
      if (w_act !== e) begin
        n_err++;
        $display("FAIL cycle_state%0d op=%b: actual %h required %h", e.st, opcode, w_act, e);
      end
      if (MemRead && MemWrite) begin
        n_err++;
        $display("FAIL mem_rd_wr_excl: actual MemRead=1 MemWrite=1 required not both");
      end
    end
  end

  logic [5:0] legal_ops[7];
  logic [5:0] rop;

  initial begin
    legal_ops = '{6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b001010, 6'b100011, 6'b101011};
    mem_ready = 1'b1;
    #12 check_now("reset_outputs", '0);
    @(posedge clk);
    #1 check_now("reset_outputs_hold", '0);
    mem_ready = 1'b0;
    rst = 1'b0;

    run_instr(6'b000000, 0, 0, 0);
    run_instr(6'b100011, 0, 3, 0);
    run_instr(6'b101011, 1, 2, 0);
    run_instr(6'b000100, 0, 0, 0);
    run_instr(6'b111111, 0, 0, 0);
    run_instr(6'b000010, 0, 0, 0);
    run_instr(6'b001010, 2, 0, 0);
    run_instr(6'b101011, 0, 2, 1);
    run_instr(6'b001000, 0, 0, 0);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        do rop = 6'($urandom);
        while (rop inside {legal_ops});
      end else begin
        rop = legal_ops[$urandom_range(0, 6)];
      end
      run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: actual %0d entries left required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
